// File: rtl/ifft_out_framer.sv
// Frames a continuous IFFT sample stream into a FWFT FIFO tagged with end-of-frame flags.
// Optional `IFFT_FRAMER_SYNCCHK_EN enables sync checking and realignment in RUN.
module ifft_out_framer #(
  parameter int LGSIZE = 11,
  parameter int WIDTH  = 16,
  parameter int LGFIFO = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  input  logic [2*WIDTH-1:0] i_sample,
  input  logic               i_sync,
  output logic [2*WIDTH-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_overflow,
  output logic               o_sync_err
);

  localparam int DEPTH = 1 << LGFIFO;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [LGSIZE-1:0]   cnt;
  logic [LGSIZE-1:0]   idx;
  logic [LGFIFO-1:0]   wr_ptr;
  logic [LGFIFO-1:0]   rd_ptr;
  logic [LGFIFO:0]     count;
  logic [2*WIDTH:0]    mem [DEPTH];
  logic                take;
  logic                pop;
  logic                full;
  logic                push;
  logic                realign;
  logic                overflow;

  // Handshake: a transfer happens on every edge where o_valid && i_ready; the
  // head stays stable otherwise. Upstream has no back-pressure, so i_ce samples
  // that meet a full FIFO without a pop are dropped.
  always_comb begin
    pop     = (count != '0) && i_ready;
    full    = (count == (LGFIFO+1)'(DEPTH));
    take    = i_ce && ((state == RUN) || i_sync);
    realign = 1'b0;
`ifdef IFFT_FRAMER_SYNCCHK_EN
    realign = (state == RUN) && i_ce && i_sync && (cnt != '0);
`endif
    idx  = ((state == IDLE) || realign) ? '0 : cnt;
    push = take && (!full || pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Counter advances even on a dropped sample to keep frame alignment.
      if (take) begin
        state <= RUN;
        cnt   <= idx + LGSIZE'(1);
      end
      if (push) wr_ptr <= wr_ptr + LGFIFO'(1);
      if (pop)  rd_ptr <= rd_ptr + LGFIFO'(1);
      case ({push, pop})
        2'b10:   count <= count + (LGFIFO+1)'(1);
        2'b01:   count <= count - (LGFIFO+1)'(1);
        default: count <= count;
      endcase
      if (take && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem[wr_ptr] <= {(idx == '1), i_sample};
  end

`ifdef IFFT_FRAMER_SYNCCHK_EN
  logic sync_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_err <= 1'b0;
    end else if ((state == RUN) && i_ce && (i_sync ? (cnt != '0) : (cnt == '0))) begin
      sync_err <= 1'b1;
    end
  end

  assign o_sync_err = sync_err;
`else
  assign o_sync_err = 1'b0;
`endif

  assign o_valid    = (count != '0);
  assign o_data     = mem[rd_ptr][2*WIDTH-1:0];
  assign o_last     = o_valid && mem[rd_ptr][2*WIDTH];
  assign o_overflow = overflow;

endmodule

// File: tb/tb_ifft_out_framer.sv
// Bench for ifft_out_framer (LGSIZE=3, LGFIFO=2): queue-based frame model,
// per-cycle compare, directed scenarios with literal expectations, random phase.
module tb_ifft_out_framer;
  localparam int LGSIZE = 3;
  localparam int WIDTH  = 16;
  localparam int LGFIFO = 2;
  localparam int FRAME  = 1 << LGSIZE;
  localparam int DEPTH  = 1 << LGFIFO;

  logic              clk = 1'b0;
  logic              reset;
  logic              ce;
  logic              sync;
  logic              ready;
  logic [2*WIDTH-1:0] sample;
  logic [2*WIDTH-1:0] o_data;
  logic              o_valid;
  logic              o_last;
  logic              o_overflow;
  logic              o_sync_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: queue of {last, data}, frame position, sticky flags.
  logic [2*WIDTH:0] exp_q[$];
  logic [2*WIDTH:0] dut_log[$];
  logic [2*WIDTH:0] e;
  bit               m_run;
  int               m_idx;
  bit               m_ovf;
  bit               m_serr;
  bit               m_take;

  ifft_out_framer #(.LGSIZE(LGSIZE), .WIDTH(WIDTH), .LGFIFO(LGFIFO)) dut (
    .i_clk(clk), .i_reset(reset), .i_ce(ce), .i_sample(sample), .i_sync(sync),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready), .o_last(o_last),
    .o_overflow(o_overflow), .o_sync_err(o_sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per rising edge from the stable inputs.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_run  = 1'b0;
      m_idx  = 0;
      m_ovf  = 1'b0;
      m_serr = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ready) e = exp_q.pop_front();
      if (ce) begin
        m_take = 1'b0;
        if (!m_run) begin
          if (sync) begin
            m_run  = 1'b1;
            m_idx  = 0;
            m_take = 1'b1;
          end
        end else begin
          m_take = 1'b1;
`ifdef IFFT_FRAMER_SYNCCHK_EN
          if (sync && m_idx != 0) begin
            m_serr = 1'b1;
            m_idx  = 0;
          end else if (!sync && m_idx == 0) begin
            m_serr = 1'b1;
          end
`endif
        end
        if (m_take) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({(m_idx == FRAME-1), sample});
          else m_ovf = 1'b1;
          m_idx = (m_idx + 1) % FRAME;
        end
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", o_valid, exp_q.size() != 0);
      check("o_last", o_last, (exp_q.size() != 0) ? exp_q[0][2*WIDTH] : 1'b0);
      if (exp_q.size() != 0) check("o_data", o_data, exp_q[0][2*WIDTH-1:0]);
      check("o_overflow", o_overflow, m_ovf);
      check("o_sync_err", o_sync_err, m_serr);
      if (o_valid && ready) dut_log.push_back({o_last, o_data});
    end
  end

  task automatic cyc(input bit c, input bit s, input logic [31:0] d, input bit r);
    @(posedge clk); #1;
    reset = 1'b0; ce = c; sync = s; sample = d; ready = r;
  endtask

  task automatic rst_cyc(input bit c, input bit s, input logic [31:0] d, input bit r);
    @(posedge clk); #1;
    reset = 1'b1; ce = c; sync = s; sample = d; ready = r;
  endtask

  int nl;
  logic [31:0] last_data;
  int rp;

  initial begin
    reset = 1'b1; ce = 1'b0; sync = 1'b0; sample = '0; ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    cyc(0, 0, 0, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_serr", o_sync_err, 0);

    // Pre-sync samples discarded, then one full frame.
    dut_log.delete();
    cyc(1, 0, 32'h1, 1);
    cyc(1, 0, 32'h2, 1);
    cyc(1, 1, 32'h0001_0002, 1);
    check("pre_write_valid", o_valid, 0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1, 0, 32'h100 + k, 1);
      if (k == 1) check("latency1_valid", o_valid, 1);
    end
    repeat (4) cyc(0, 0, 0, 1);
    check("f1_count", dut_log.size(), 8);
    check("f1_first", dut_log[0], {1'b0, 32'h0001_0002});
    check("f1_last", dut_log[7], {1'b1, 32'h107});
    nl = 0;
    foreach (dut_log[i]) if (dut_log[i][2*WIDTH]) nl++;
    check("f1_nlast", nl, 1);

    // Overflow with stalled downstream; alignment survives drops.
    dut_log.delete();
    for (int k = 0; k <= 5; k++) begin
      cyc(1, 0, 32'h200 + k, 0);
      if (k == 4) check("ovf_at_4", o_overflow, 0);
      if (k == 5) check("ovf_at_5", o_overflow, 1);
    end
    cyc(1, 0, 32'h206, 1);
    cyc(1, 0, 32'h207, 1);
    repeat (8) cyc(0, 0, 0, 1);
    check("ovf_count", dut_log.size(), 6);
    check("ovf_head", dut_log[0], {1'b0, 32'h200});
    check("ovf_fourth", dut_log[3], {1'b0, 32'h203});
    check("ovf_idx7", dut_log[5], {1'b1, 32'h207});
    for (int k = 0; k < FRAME; k++) cyc(1, 0, 32'h300 + k, 1);
    repeat (4) cyc(0, 0, 0, 1);
    check("next_frame_last", dut_log[13], {1'b1, 32'h307});
    check("next_frame_idx6", dut_log[12], {1'b0, 32'h306});

    // Full FIFO with simultaneous pop and write: no drop.
    rst_cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h400, 0);
    for (int k = 1; k <= 3; k++) cyc(1, 0, 32'h400 + k, 0);
    cyc(1, 0, 32'h404, 1);
    cyc(0, 0, 0, 0);
    check("full_pop_ovf", o_overflow, 0);
    dut_log.delete();
    repeat (2) cyc(0, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 1);
    check("full_pop_count", dut_log.size(), 4);
    check("full_pop_head", dut_log[0], {1'b0, 32'h401});
    check("full_pop_tail", dut_log[3], {1'b0, 32'h404});

    // Reset mid-frame with 3 entries buffered, together with ce and pop.
    rst_cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h500, 0);
    cyc(1, 0, 32'h501, 0);
    cyc(1, 0, 32'h502, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 32'h503, 0);
    rst_cyc(1, 0, 32'h504, 1);
    cyc(1, 0, 32'h505, 1);
    check("mid_rst_valid", o_valid, 0);
    dut_log.delete();
    cyc(1, 0, 32'h506, 1);
    cyc(1, 0, 32'h507, 1);
    repeat (2) cyc(0, 0, 0, 1);
    check("post_rst_idle", o_valid, 0);
    check("post_rst_nolog", dut_log.size(), 0);
    cyc(1, 1, 32'h508, 1);
    cyc(1, 0, 32'h509, 1);
    repeat (3) cyc(0, 0, 0, 1);
    check("resync_count", dut_log.size(), 2);
    check("resync_head", dut_log[0], {1'b0, 32'h508});

    // Sync asserted at index 5.
    rst_cyc(0, 0, 0, 1);
    dut_log.delete();
    cyc(1, 1, 32'h600, 1);
    for (int k = 1; k <= 13; k++) cyc(1, (k == 5), 32'h600 + k, 1);
    repeat (4) cyc(0, 0, 0, 1);
    nl = 0;
    last_data = '0;
    foreach (dut_log[i]) if (dut_log[i][2*WIDTH]) begin
      nl++;
      last_data = dut_log[i][31:0];
    end
    check("sc_count", dut_log.size(), 14);
    check("sc_nlast", nl, 1);
`ifdef IFFT_FRAMER_SYNCCHK_EN
    check("sc_last_data", last_data, 32'h60c);
    check("sc_err", o_sync_err, 1);
`else
    check("sc_last_data", last_data, 32'h607);
    check("sc_err", o_sync_err, 0);
`endif

    // Randomized phase; the compare process checks every cycle.
    rst_cyc(0, 0, 0, 0);
    rp = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rp = $urandom_range(0, 4);
      if ($urandom_range(0, 999) < 4)
        rst_cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
      else
        cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) < rp);
    end
    repeat (8) cyc(0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
